control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter EARLY_END, default 1: 1 = return to T0 after an instruction's last active step; 0 = always run T0..T5.
REQ-002 SHALL provide port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL provide port opcode  input  4  current instruction-register opcode field.
REQ-005 SHALL provide port flag_zero  input  1  registered ALU zero flag.
REQ-006 SHALL provide port flag_carry  input  1  registered ALU carry flag.
REQ-007 SHALL provide ports oe_pc, oe_ram, oe_ir, oe_a, oe_alu  output  1 each  bus drive enables; oe_ir drives the operand nibble.
REQ-008 SHALL provide ports load_mar, load_ir, load_a, load_b, load_ram, load_out, load_pc, load_flags  output  1 each  register load strobes.
REQ-009 SHALL provide ports pc_enable, alu_sub, halt  output  1 each  PC increment, ALU subtract select, halted indicator.
REQ-010 SHALL provide port tstate  output  3  current step index, 0..5.

Function
REQ-011 SHALL sequence steps T0..T5 with a 3-bit step counter; all control outputs SHALL be combinational from step, opcode and flags.
REQ-012 T0 SHALL assert oe_pc and load_mar.
REQ-013 T1 SHALL assert oe_ram, load_ir and pc_enable.
REQ-014 Opcode map SHALL be: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT.
REQ-015 Opcodes 9-D SHALL execute as NOP.
REQ-016 LDA SHALL run: T2 oe_ir+load_mar; T3 oe_ram+load_a.
REQ-017 ADD SHALL run: T2 oe_ir+load_mar; T3 oe_ram+load_b; T4 oe_alu+load_a+load_flags.
REQ-018 SUB SHALL run as ADD, with alu_sub additionally asserted in T4.
REQ-019 STA SHALL run: T2 oe_ir+load_mar; T3 oe_a+load_ram.
REQ-020 LDI, JMP, OUT SHALL each run a single T2 step: LDI oe_ir+load_a; JMP oe_ir+load_pc; OUT oe_a+load_out.
REQ-021 JC/JZ SHALL assert oe_ir+load_pc in T2 only when flag_carry/flag_zero is 1 at T2; otherwise T2 SHALL assert nothing.
REQ-022 NOP SHALL assert no signals in T2.
REQ-023 With EARLY_END=1, the step after an instruction's last active step SHALL be T0: NOP/LDI/JMP/JC/JZ/OUT 3 cycles, LDA/STA 4, ADD/SUB 5.
REQ-024 With EARLY_END=0, every instruction SHALL take 6 cycles; unused steps SHALL assert nothing; T5 SHALL wrap to T0.
REQ-025 HLT at T2 SHALL enter a sticky HALTED state on the next edge: halt=1, tstate frozen at 2, all other outputs 0; only reset SHALL exit.
REQ-026 At most one oe_* signal SHALL be high in any cycle.
REQ-027 Opcode and flags SHALL be sampled combinationally each step; an opcode change mid-instruction SHALL NOT corrupt the step counter or the T0 return.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, force tstate=0, clear HALTED, halt=0, and produce the T0 control pattern.
REQ-029 Reset asserted mid-instruction or while halted SHALL abort the instruction; the first edge after release SHALL advance to T1.

Structure
REQ-030 Opcode constants, step encodings and control-word bit positions SHALL live in shared package control_pkg.
REQ-031 The opcode/step/flag-to-control-word logic SHALL be a combinational sub-module, control_decode; control_sequencer holds only the step counter and halt state.

Verification
REQ-032 Release reset, opcode=1 (LDA), clk x4 -> tstate 0,1,2,3,0; load_a only in T3; oe_ram in T1 and T3.
REQ-033 opcode=2 then 3 -> 5-cycle instructions each; alu_sub=0 for ADD T4 and 1 for SUB T4; load_flags only in T4.
REQ-034 opcode=7 with flag_carry=0, then flag_carry=1 -> load_pc low, then high in T2; both instructions return to T0 after 3 cycles.
REQ-035 opcode=F -> halt=1 after T2, tstate stays 2 for 20 clocks, no strobes; reset=0 pulse -> tstate=0, halt=0.
REQ-036 Assert reset=0 asynchronously during ADD T3 -> outputs show the T0 pattern before the next edge; after release, T1 follows.
REQ-037 All 16 opcodes with both flag values, EARLY_END=0 and 1 -> at most one oe_* high per cycle; cycle counts per REQ-023/024.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: opcode map, step encodings,
// control-word bit positions, and the per-opcode last-active-step lookup.
package control_pkg;

    // Opcode map. 9..D have no entry and decode as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_t;

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_HALTED = 1'b1
    } seq_state_t;

    // Control-word bit positions.
    localparam int CW_OE_PC      = 0;
    localparam int CW_OE_RAM     = 1;
    localparam int CW_OE_IR      = 2;
    localparam int CW_OE_A       = 3;
    localparam int CW_OE_ALU     = 4;
    localparam int CW_LOAD_MAR   = 5;
    localparam int CW_LOAD_IR    = 6;
    localparam int CW_LOAD_A     = 7;
    localparam int CW_LOAD_B     = 8;
    localparam int CW_LOAD_RAM   = 9;
    localparam int CW_LOAD_OUT   = 10;
    localparam int CW_LOAD_PC    = 11;
    localparam int CW_LOAD_FLAGS = 12;
    localparam int CW_PC_ENABLE  = 13;
    localparam int CW_ALU_SUB    = 14;
    localparam int CW_W          = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Last step that does useful work for an opcode. Everything not listed
    // (including the conditional jumps, whose T2 may be empty) ends at T2.
    function automatic step_t last_step(input logic [3:0] op);
        step_t s;
        case (op)
            OP_LDA, OP_STA: s = T3;
            OP_ADD, OP_SUB: s = T4;
            default:        s = T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the datapath.
//   opcode/flag_zero/flag_carry : datapath -> sequencer
//   oe_*                        : bus drive enables (oe_ir drives operand nibble)
//   load_*                      : register load strobes
//   pc_enable/alu_sub/halt      : PC increment, ALU subtract, halted indicator
//   tstate                      : current step index 0..5
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       flag_zero;
    logic       flag_carry;

    logic       oe_pc;
    logic       oe_ram;
    logic       oe_ir;
    logic       oe_a;
    logic       oe_alu;

    logic       load_mar;
    logic       load_ir;
    logic       load_a;
    logic       load_b;
    logic       load_ram;
    logic       load_out;
    logic       load_pc;
    logic       load_flags;

    logic       pc_enable;
    logic       alu_sub;
    logic       halt;
    logic [2:0] tstate;

    // Sequencer side.
    modport master (
        input  opcode, flag_zero, flag_carry,
        output oe_pc, oe_ram, oe_ir, oe_a, oe_alu,
        output load_mar, load_ir, load_a, load_b, load_ram, load_out, load_pc, load_flags,
        output pc_enable, alu_sub, halt, tstate
    );

    // Datapath side.
    modport slave (
        output opcode, flag_zero, flag_carry,
        input  oe_pc, oe_ram, oe_ir, oe_a, oe_alu,
        input  load_mar, load_ir, load_a, load_b, load_ram, load_out, load_pc, load_flags,
        input  pc_enable, alu_sub, halt, tstate
    );
endinterface

// File: rtl/control_decode.sv
// Combinational microcode decode: step + opcode + flags -> control word.
// Ports:
//   step       : current step T0..T5
//   opcode     : instruction opcode
//   flag_zero  : ALU zero flag (JZ condition)
//   flag_carry : ALU carry flag (JC condition)
//   cw         : control word, bit positions from control_pkg
//   last       : current step is at or past the opcode's last active step
//   hlt_req    : HLT is being executed in T2
module control_decode
    import control_pkg::*;
(
    input  step_t      step,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output ctrl_word_t cw,
    output logic       last,
    output logic       hlt_req
);

    always_comb begin
        cw = '0;
        case (step)
            T0: begin
                cw[CW_OE_PC]    = 1'b1;
                cw[CW_LOAD_MAR] = 1'b1;
            end
            T1: begin
                cw[CW_OE_RAM]    = 1'b1;
                cw[CW_LOAD_IR]   = 1'b1;
                cw[CW_PC_ENABLE] = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_OE_IR]    = 1'b1;
                        cw[CW_LOAD_MAR] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_OE_IR]  = 1'b1;
                        cw[CW_LOAD_A] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_OE_IR]   = 1'b1;
                        cw[CW_LOAD_PC] = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_OE_IR]   = flag_carry;
                        cw[CW_LOAD_PC] = flag_carry;
                    end
                    OP_JZ: begin
                        cw[CW_OE_IR]   = flag_zero;
                        cw[CW_LOAD_PC] = flag_zero;
                    end
                    OP_OUT: begin
                        cw[CW_OE_A]     = 1'b1;
                        cw[CW_LOAD_OUT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_OE_RAM] = 1'b1;
                        cw[CW_LOAD_A] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_OE_RAM] = 1'b1;
                        cw[CW_LOAD_B] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_OE_A]     = 1'b1;
                        cw[CW_LOAD_RAM] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_OE_ALU]     = 1'b1;
                    cw[CW_LOAD_A]     = 1'b1;
                    cw[CW_LOAD_FLAGS] = 1'b1;
                    cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // ">=" rather than "==" so an opcode that changes to a shorter
    // instruction mid-flight still terminates instead of running to T5.
    assign last    = (step >= T2) && (step >= last_step(opcode));
    assign hlt_req = (step == T2) && (opcode == OP_HLT);

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: step counter T0..T5 plus sticky HALTED state.
// All control outputs come combinationally from control_decode.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : control_sequencer_if.master (opcode/flags in, controls/tstate out)
// Parameter:
//   EARLY_END : 1 = return to T0 after the last active step, 0 = always T0..T5
module control_sequencer
    import control_pkg::*;
#(
    parameter bit EARLY_END = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    step_t      step, step_nxt;
    seq_state_t state, state_nxt;
    ctrl_word_t cw;
    logic       last;
    logic       hlt_req;
    logic       run;

    control_decode u_decode (
        .step       (step),
        .opcode     (bus.opcode),
        .flag_zero  (bus.flag_zero),
        .flag_carry (bus.flag_carry),
        .cw         (cw),
        .last       (last),
        .hlt_req    (hlt_req)
    );

    // Async reset clears the step counter directly, so the T0 pattern
    // appears on the outputs without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEQ_RUN;
            step  <= T0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            SEQ_RUN: begin
                if (hlt_req) begin
                    // Freeze at T2; only reset leaves HALTED.
                    state_nxt = SEQ_HALTED;
                end else if ((EARLY_END && last) || step >= T5) begin
                    step_nxt = T0;
                end else begin
                    step_nxt = step_t'(step + 3'd1);
                end
            end
            SEQ_HALTED: ;
            default: begin
                state_nxt = SEQ_RUN;
                step_nxt  = T0;
            end
        endcase
    end

    assign run = (state == SEQ_RUN);

    assign bus.oe_pc      = run & cw[CW_OE_PC];
    assign bus.oe_ram     = run & cw[CW_OE_RAM];
    assign bus.oe_ir      = run & cw[CW_OE_IR];
    assign bus.oe_a       = run & cw[CW_OE_A];
    assign bus.oe_alu     = run & cw[CW_OE_ALU];
    assign bus.load_mar   = run & cw[CW_LOAD_MAR];
    assign bus.load_ir    = run & cw[CW_LOAD_IR];
    assign bus.load_a     = run & cw[CW_LOAD_A];
    assign bus.load_b     = run & cw[CW_LOAD_B];
    assign bus.load_ram   = run & cw[CW_LOAD_RAM];
    assign bus.load_out   = run & cw[CW_LOAD_OUT];
    assign bus.load_pc    = run & cw[CW_LOAD_PC];
    assign bus.load_flags = run & cw[CW_LOAD_FLAGS];
    assign bus.pc_enable  = run & cw[CW_PC_ENABLE];
    assign bus.alu_sub    = run & cw[CW_ALU_SUB];
    assign bus.halt       = (state == SEQ_HALTED);
    assign bus.tstate     = step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END setting,
// driven by the same opcode/flags/reset.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       flag_zero = 1'b0;
    logic       flag_carry = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_sequencer_if bus1 ();
    control_sequencer_if bus0 ();

    assign bus1.opcode     = opcode;
    assign bus1.flag_zero  = flag_zero;
    assign bus1.flag_carry = flag_carry;
    assign bus0.opcode     = opcode;
    assign bus0.flag_zero  = flag_zero;
    assign bus0.flag_carry = flag_carry;

    control_sequencer #(.EARLY_END(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    control_sequencer #(.EARLY_END(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    // {oe_pc, oe_ram, oe_ir, oe_a, oe_alu}
    logic [4:0] oe1, oe0;
    // {load_mar, load_ir, load_a, load_b, load_ram, load_out, load_pc, load_flags, pc_enable, alu_sub}
    logic [9:0] str1, str0;
    assign oe1  = {bus1.oe_pc, bus1.oe_ram, bus1.oe_ir, bus1.oe_a, bus1.oe_alu};
    assign oe0  = {bus0.oe_pc, bus0.oe_ram, bus0.oe_ir, bus0.oe_a, bus0.oe_alu};
    assign str1 = {bus1.load_mar, bus1.load_ir, bus1.load_a, bus1.load_b, bus1.load_ram,
                   bus1.load_out, bus1.load_pc, bus1.load_flags, bus1.pc_enable, bus1.alu_sub};
    assign str0 = {bus0.load_mar, bus0.load_ir, bus0.load_a, bus0.load_b, bus0.load_ram,
                   bus0.load_out, bus0.load_pc, bus0.load_flags, bus0.pc_enable, bus0.alu_sub};

    // Sample point: 1 time unit after the falling edge, well away from posedge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        // {tstate, oe, strobes, halt} expected in T0
        logic [18:0] exp_t0;
        exp_t0 = {3'd0, 5'b10000, 10'b1000000000, 1'b0};
        reset = 1'b0;
        #3;
        n_checks++;
        if ({bus1.tstate, oe1, str1, bus1.halt} !== exp_t0) begin
            n_fail++;
            $display("FAIL reset_pattern_ee1: got %h want %h", {bus1.tstate, oe1, str1, bus1.halt}, exp_t0);
        end
        n_checks++;
        if ({bus0.tstate, oe0, str0, bus0.halt} !== exp_t0) begin
            n_fail++;
            $display("FAIL reset_pattern_ee0: got %h want %h", {bus0.tstate, oe0, str0, bus0.halt}, exp_t0);
        end
        tick();
        tick();
        n_checks++;
        if (bus1.tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_held_tstate: got %0d want 0", bus1.tstate);
        end
    endtask

    task automatic test_lda();
        int exp_t[5] = '{0, 1, 2, 3, 0};
        do_reset();
        opcode = 4'h1;
        #1;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] t;
            t = exp_t[i][2:0];
            n_checks++;
            if (bus1.tstate !== t) begin
                n_fail++;
                $display("FAIL lda_tstate cyc %0d: got %0d want %0d", i, bus1.tstate, t);
            end
            n_checks++;
            if (bus1.load_a !== (t == 3'd3)) begin
                n_fail++;
                $display("FAIL lda_load_a cyc %0d: got %b want %b", i, bus1.load_a, (t == 3'd3));
            end
            n_checks++;
            if (bus1.oe_ram !== (t == 3'd1 || t == 3'd3)) begin
                n_fail++;
                $display("FAIL lda_oe_ram cyc %0d: got %b want %b", i, bus1.oe_ram, (t == 3'd1 || t == 3'd3));
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_add_sub();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 1) ? 4'h3 : 4'h2;
            #1;
            for (int i = 0; i < 6; i++) begin
                logic [2:0] t;
                t = (i == 5) ? 3'd0 : 3'(i);
                n_checks++;
                if (bus1.tstate !== t) begin
                    n_fail++;
                    $display("FAIL addsub_tstate op %0d cyc %0d: got %0d want %0d", opcode, i, bus1.tstate, t);
                end
                n_checks++;
                if (bus1.load_flags !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL addsub_load_flags op %0d cyc %0d: got %b want %b", opcode, i, bus1.load_flags, (i == 4));
                end
                n_checks++;
                if (bus1.alu_sub !== (i == 4 && k == 1)) begin
                    n_fail++;
                    $display("FAIL addsub_alu_sub op %0d cyc %0d: got %b want %b", opcode, i, bus1.alu_sub, (i == 4 && k == 1));
                end
                n_checks++;
                if (bus1.load_b !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL addsub_load_b op %0d cyc %0d: got %b want %b", opcode, i, bus1.load_b, (i == 3));
                end
                if (i < 5) tick();
            end
        end
    endtask

    task automatic test_cond_jump();
        do_reset();
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 2; k++) begin
                // The non-tested flag is held at the opposite value.
                opcode     = (j == 0) ? 4'h7 : 4'h8;
                flag_carry = (j == 0) ? k[0] : ~k[0];
                flag_zero  = (j == 0) ? ~k[0] : k[0];
                #1;
                tick();
                tick();
                n_checks++;
                if ({bus1.tstate, bus1.load_pc, bus1.oe_ir} !== {3'd2, k[0], k[0]}) begin
                    n_fail++;
                    $display("FAIL jump_t2 op %0d flag %0d: got t=%0d pc=%b ir=%b want t=2 pc=%b ir=%b",
                             opcode, k, bus1.tstate, bus1.load_pc, bus1.oe_ir, k[0], k[0]);
                end
                tick();
                n_checks++;
                if (bus1.tstate !== 3'd0) begin
                    n_fail++;
                    $display("FAIL jump_return op %0d flag %0d: got %0d want 0", opcode, k, bus1.tstate);
                end
            end
        end
        flag_carry = 1'b0;
        flag_zero  = 1'b0;
    endtask

    task automatic test_t2_patterns();
        logic [3:0]  ops[4]  = '{4'h4, 4'h5, 4'h6, 4'hE};
        logic [14:0] pat[4]  = '{{5'b00100, 10'b1000000000},   // STA: oe_ir+load_mar
                                 {5'b00100, 10'b0010000000},   // LDI: oe_ir+load_a
                                 {5'b00100, 10'b0000001000},   // JMP: oe_ir+load_pc
                                 {5'b00010, 10'b0000010000}};  // OUT: oe_a+load_out
        logic [14:0] sta_t3;
        sta_t3 = {5'b00010, 10'b0000100000};                 // STA T3: oe_a+load_ram
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            #1;
            tick();
            tick();
            n_checks++;
            if ({oe1, str1} !== pat[i]) begin
                n_fail++;
                $display("FAIL t2_pattern op %0d: got %b want %b", opcode, {oe1, str1}, pat[i]);
            end
            tick();
            if (i == 0) begin
                n_checks++;
                if ({oe1, str1} !== sta_t3) begin
                    n_fail++;
                    $display("FAIL sta_t3_pattern: got %b want %b", {oe1, str1}, sta_t3);
                end
                tick();
            end
            n_checks++;
            if (bus1.tstate !== 3'd0) begin
                n_fail++;
                $display("FAIL t2_return op %0d: got %0d want 0", opcode, bus1.tstate);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        opcode = 4'hF;
        #1;
        tick();
        tick();
        n_checks++;
        if ({bus1.tstate, bus1.halt} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_t2: got t=%0d halt=%b want t=2 halt=0", bus1.tstate, bus1.halt);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({bus1.tstate, bus1.halt, oe1, str1} !== {3'd2, 1'b1, 15'b0}) begin
                n_fail++;
                $display("FAIL halted clk %0d: got t=%0d halt=%b oe=%b str=%b want t=2 halt=1 rest 0",
                         i, bus1.tstate, bus1.halt, oe1, str1);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus1.tstate, bus1.halt, oe1, str1} !== {3'd0, 1'b0, 5'b10000, 10'b1000000000}) begin
            n_fail++;
            $display("FAIL halt_reset: got t=%0d halt=%b oe=%b str=%b want t=0 halt=0 T0 pattern",
                     bus1.tstate, bus1.halt, oe1, str1);
        end
        opcode = 4'h0;
        reset  = 1'b1;
        tick();
        n_checks++;
        if (bus1.tstate !== 3'd1) begin
            n_fail++;
            $display("FAIL halt_release_t1: got %0d want 1", bus1.tstate);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        opcode = 4'h2;
        #1;
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus1.tstate, bus1.load_b} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL async_pre_t3: got t=%0d load_b=%b want t=3 load_b=1", bus1.tstate, bus1.load_b);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus1.tstate, oe1, str1} !== {3'd0, 5'b10000, 10'b1000000000}) begin
            n_fail++;
            $display("FAIL async_reset_t0: got t=%0d oe=%b str=%b want t=0 oe=10000 str=1000000000",
                     bus1.tstate, oe1, str1);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus1.tstate, bus1.load_ir, bus1.pc_enable} !== {3'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_release_t1: got t=%0d load_ir=%b pc_en=%b want t=1 1 1",
                     bus1.tstate, bus1.load_ir, bus1.pc_enable);
        end
    endtask

    task automatic test_opcode_change();
        do_reset();
        opcode = 4'h2;
        #1;
        tick();
        tick();
        tick();
        // ADD turns into NOP at T3: already past NOP's last step.
        opcode = 4'h0;
        #1;
        tick();
        n_checks++;
        if (bus1.tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL opcode_change_return: got %0d want 0", bus1.tstate);
        end
    endtask

    task automatic test_all_opcodes();
        // Cycles until first return to T0; 0 = never (HLT).
        int cyc1[16] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0};
        int cyc0[16] = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 0};
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 2; f++) begin
                int first1, first0;
                do_reset();
                opcode     = 4'(op);
                flag_zero  = f[0];
                flag_carry = f[0];
                #1;
                first1 = 0;
                first0 = 0;
                for (int c = 0; c < 7; c++) begin
                    n_checks++;
                    if ($countones(oe1) > 1) begin
                        n_fail++;
                        $display("FAIL oe_onehot_ee1 op %0d f %0d cyc %0d: got oe=%b want at most one", op, f, c, oe1);
                    end
                    n_checks++;
                    if ($countones(oe0) > 1) begin
                        n_fail++;
                        $display("FAIL oe_onehot_ee0 op %0d f %0d cyc %0d: got oe=%b want at most one", op, f, c, oe0);
                    end
                    if (bus0.tstate == 3'd5) begin
                        n_checks++;
                        if ({oe0, str0, bus0.halt} !== 16'b0) begin
                            n_fail++;
                            $display("FAIL ee0_t5_idle op %0d f %0d: got oe=%b str=%b want 0", op, f, oe0, str0);
                        end
                    end
                    if (c < 6) begin
                        tick();
                        if (first1 == 0 && bus1.tstate == 3'd0) first1 = c + 1;
                        if (first0 == 0 && bus0.tstate == 3'd0) first0 = c + 1;
                    end
                end
                n_checks++;
                if (first1 != cyc1[op]) begin
                    n_fail++;
                    $display("FAIL cycles_ee1 op %0d f %0d: got %0d want %0d", op, f, first1, cyc1[op]);
                end
                n_checks++;
                if (first0 != cyc0[op]) begin
                    n_fail++;
                    $display("FAIL cycles_ee0 op %0d f %0d: got %0d want %0d", op, f, first0, cyc0[op]);
                end
            end
        end
        flag_zero  = 1'b0;
        flag_carry = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_cond_jump();
        test_t2_patterns();
        test_halt();
        test_async_reset();
        test_opcode_change();
        test_all_opcodes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
